// File: rtl/wallace_mac_pkg.sv
// rtl/wallace_mac_pkg.sv - CSA tree sizing helpers and beat sideband type for wallace_mac_pipe
package wallace_mac_pkg;

  function automatic int csa_rows(input int n);
    return n - n / 3;
  endfunction

  function automatic int csa_levels(input int n);
    int r;
    int l;
    r = n;
    l = 0;
    while (r > 2) begin
      r = csa_rows(r);
      l++;
    end
    return l;
  endfunction

  function automatic int rows_after(input int n, input int levels);
    int r;
    r = n;
    for (int i = 0; i < levels; i++) r = csa_rows(r);
    return r;
  endfunction

  // Stage 1 takes the larger half of the levels; the rest run in stage 2.
  function automatic int stage1_levels(input int n);
    return (csa_levels(n) + 1) / 2;
  endfunction

  // Default-width tree shape: WIDTH partial products plus the two's-complement correction row.
  localparam int DEF_WIDTH = 32;
  localparam int L1        = stage1_levels(DEF_WIDTH + 1);
  localparam int R1        = rows_after(DEF_WIDTH + 1, L1);

  typedef struct packed {
    logic is_signed;
    logic acc_en;
    logic acc_clear;
  } sideband_t;

endpackage

// File: rtl/csa_row.sv
// rtl/csa_row.sv - bitwise 3:2 carry-save compressor, carry pre-shifted into its weight
module csa_row #(
  parameter int W = 8
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] z,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);

  logic [W-1:0] maj;

  assign sum   = x ^ y ^ z;
  assign maj   = (x & y) | (x & z) | (y & z);
  assign carry = maj << 1;

endmodule

// File: rtl/wallace_mac_pipe.sv
// rtl/wallace_mac_pipe.sv - 3-stage stallable Wallace-tree multiply-accumulate with sticky overflow
module wallace_mac_pipe #(
  parameter int WIDTH     = 32,
  parameter int ACC_WIDTH = 72
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 is_signed,
  input  logic                 acc_en,
  input  logic                 acc_clear,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   prod,
  output logic [ACC_WIDTH-1:0] acc,
  output logic                 acc_ovf
);
  import wallace_mac_pkg::*;

  localparam int PW    = 2 * WIDTH;
  localparam int NROWS = WIDTH + 1;
  localparam int LT    = csa_levels(NROWS);
  localparam int L1_W  = stage1_levels(NROWS);
  localparam int R1_W  = rows_after(NROWS, L1_W);

  if (ACC_WIDTH < 2 * WIDTH || WIDTH < 4 || WIDTH > 64) begin : g_bad_params
    $error("wallace_mac_pipe: need 4 <= WIDTH <= 64 and ACC_WIDTH >= 2*WIDTH");
  end

  logic            en;
  logic [PW-1:0]   a_ext;
  logic [PW-1:0]   pp      [NROWS];
  logic [PW-1:0]   lvl_in  [LT+1][NROWS];
  logic [PW-1:0]   lvl_out [LT][NROWS];
  logic [PW-1:0]   s1_rows [R1_W];
  logic            s1_valid, s2_valid;
  sideband_t       s1_sb, s2_sb;
  logic [PW-1:0]   s2_r0, s2_r1;

  assign en       = !(out_valid && !out_ready);
  assign in_ready = en;

  // Signed mode negates the b-MSB row as ~row plus a separate +1 correction row.
  assign a_ext = is_signed ? PW'($signed(a)) : PW'(a);
  always_comb begin
    for (int i = 0; i < WIDTH; i++) pp[i] = b[i] ? (a_ext << i) : '0;
    pp[WIDTH] = '0;
    if (is_signed && b[WIDTH-1]) begin
      pp[WIDTH-1] = ~(a_ext << (WIDTH - 1));
      pp[WIDTH]   = PW'(1);
    end
  end

  assign lvl_in[0] = pp;

  for (genvar l = 0; l < LT; l++) begin : g_lvl
    localparam int CIN  = rows_after(NROWS, l);
    localparam int NG   = CIN / 3;
    localparam int COUT = csa_rows(CIN);
    for (genvar g = 0; g < NG; g++) begin : g_csa
      csa_row #(.W(PW)) u_csa (
        .x    (lvl_in[l][3*g]),
        .y    (lvl_in[l][3*g+1]),
        .z    (lvl_in[l][3*g+2]),
        .sum  (lvl_out[l][2*g]),
        .carry(lvl_out[l][2*g+1])
      );
    end
    for (genvar r = 2 * NG; r < COUT; r++) begin : g_pass
      assign lvl_out[l][r] = lvl_in[l][r+NG];
    end
    for (genvar r = COUT; r < NROWS; r++) begin : g_zero
      assign lvl_out[l][r] = '0;
    end
    // The stage-1 register sits between level L1_W-1 and level L1_W.
    if (l + 1 == L1_W) begin : g_cut
      for (genvar r = 0; r < NROWS; r++) begin : g_row
        if (r < R1_W) begin : g_reg
          assign lvl_in[l+1][r] = s1_rows[r];
        end else begin : g_nil
          assign lvl_in[l+1][r] = '0;
        end
      end
    end else begin : g_thru
      assign lvl_in[l+1] = lvl_out[l];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sb    <= '0;
      for (int r = 0; r < R1_W; r++) s1_rows[r] <= '0;
      s2_valid <= 1'b0;
      s2_sb    <= '0;
      s2_r0    <= '0;
      s2_r1    <= '0;
    end else if (en) begin
      s1_valid <= in_valid;
      s1_sb    <= {is_signed, acc_en, acc_clear};
      for (int r = 0; r < R1_W; r++) s1_rows[r] <= lvl_out[L1_W-1][r];
      s2_valid <= s1_valid;
      s2_sb    <= s1_sb;
      s2_r0    <= lvl_in[LT][0];
      s2_r1    <= lvl_in[LT][1];
    end
  end

  logic [PW-1:0]        prod_n;
  logic [ACC_WIDTH-1:0] ext, base, acc_n;
  logic [ACC_WIDTH:0]   sum_x;
  logic                 ovf_beat, ovf_n;

  always_comb begin
    prod_n   = s2_r0 + s2_r1;
    ext      = s2_sb.is_signed ? ACC_WIDTH'($signed(prod_n)) : ACC_WIDTH'(prod_n);
    base     = s2_sb.acc_clear ? '0 : acc;
    sum_x    = {1'b0, base} + {1'b0, ext};
    acc_n    = s2_sb.acc_en ? sum_x[ACC_WIDTH-1:0] : base;
    ovf_beat = 1'b0;
    if (s2_sb.acc_en) begin
      if (s2_sb.is_signed)
        ovf_beat = (base[ACC_WIDTH-1] == ext[ACC_WIDTH-1]) &&
                   (sum_x[ACC_WIDTH-1] != base[ACC_WIDTH-1]);
      else
        ovf_beat = sum_x[ACC_WIDTH];
    end
    ovf_n = (s2_sb.acc_clear ? 1'b0 : acc_ovf) | ovf_beat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      prod      <= '0;
      acc       <= '0;
      acc_ovf   <= 1'b0;
    end else if (en) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        prod    <= prod_n;
        acc     <= acc_n;
        acc_ovf <= ovf_n;
      end
    end
  end

endmodule

// File: tb/tb_wallace_mac_pipe.sv
// tb/tb_wallace_mac_pipe.sv - directed self-checking bench for wallace_mac_pipe
module tb_wallace_mac_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid = 0, in_ready, is_signed = 0, acc_en = 0, acc_clear = 0;
  logic        out_valid, out_ready = 1, acc_ovf;
  logic [31:0] a = 0, b = 0;
  logic [63:0] prod;
  logic [71:0] acc;

  logic        in_valid2 = 0, in_ready2, is_signed2 = 0, acc_en2 = 0, acc_clear2 = 0;
  logic        out_valid2, acc_ovf2;
  logic [31:0] a2 = 0, b2 = 0;
  logic [63:0] prod2, acc2;

  int passed = 0;
  int total  = 0;

  wallace_mac_pipe #(.WIDTH(32), .ACC_WIDTH(72)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .is_signed(is_signed), .acc_en(acc_en), .acc_clear(acc_clear),
    .out_valid(out_valid), .out_ready(out_ready), .prod(prod), .acc(acc), .acc_ovf(acc_ovf)
  );

  wallace_mac_pipe #(.WIDTH(32), .ACC_WIDTH(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .is_signed(is_signed2), .acc_en(acc_en2), .acc_clear(acc_clear2),
    .out_valid(out_valid2), .out_ready(1'b1), .prod(prod2), .acc(acc2), .acc_ovf(acc_ovf2)
  );

  // Issues one beat, confirms out_valid is low after 2 cycles and high after 3, returns outputs.
  task automatic run_one(input bit sel, input logic [31:0] av, input logic [31:0] bv,
                         input logic s, input logic e, input logic c,
                         output logic [63:0] p, output logic [71:0] ac,
                         output logic ov, output bit lat_ok);
    @(posedge clk); #1;
    if (!sel) begin
      in_valid = 1; a = av; b = bv; is_signed = s; acc_en = e; acc_clear = c;
    end else begin
      in_valid2 = 1; a2 = av; b2 = bv; is_signed2 = s; acc_en2 = e; acc_clear2 = c;
    end
    @(posedge clk); #1;
    in_valid = 0; in_valid2 = 0;
    lat_ok = 1;
    @(posedge clk); #1;
    if ((sel ? out_valid2 : out_valid) !== 1'b0) lat_ok = 0;
    @(posedge clk); #1;
    if ((sel ? out_valid2 : out_valid) !== 1'b1) lat_ok = 0;
    p  = sel ? prod2 : prod;
    ac = sel ? {8'h00, acc2} : acc;
    ov = sel ? acc_ovf2 : acc_ovf;
  endtask

  task automatic test_reset;
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
    total++; if (prod !== 64'h0) $display("FAIL reset_prod: got %h want 0", prod); else passed++;
    total++; if (acc !== 72'h0) $display("FAIL reset_acc: got %h want 0", acc); else passed++;
    total++; if (acc_ovf !== 1'b0) $display("FAIL reset_acc_ovf: got %b want 0", acc_ovf); else passed++;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else passed++;
    total++; if (out_valid2 !== 1'b0) $display("FAIL reset_out_valid64: got %b want 0", out_valid2); else passed++;
  endtask

  task automatic test_unsigned_max;
    logic [63:0] p; logic [71:0] ac; logic ov; bit ok;
    run_one(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1, p, ac, ov, ok);
    total++; if (!ok) $display("FAIL umax_latency: got early/late out_valid want 3 cycles"); else passed++;
    total++; if (p !== 64'hFFFF_FFFE_0000_0001) $display("FAIL umax_prod: got %h want fffffffe00000001", p); else passed++;
  endtask

  task automatic test_signed;
    logic [63:0] p; logic [71:0] ac; logic ov; bit ok;
    run_one(0, 32'hFFFF_FFFD, 32'd7, 1, 0, 1, p, ac, ov, ok);
    total++; if (!ok) $display("FAIL signed_latency: got early/late out_valid want 3 cycles"); else passed++;
    total++; if (p !== 64'hFFFF_FFFF_FFFF_FFEB) $display("FAIL signed_neg3x7: got %h want ffffffffffffffeb", p); else passed++;
    run_one(0, 32'h8000_0000, 32'h8000_0000, 1, 0, 1, p, ac, ov, ok);
    total++; if (p !== 64'h4000_0000_0000_0000) $display("FAIL signed_minxmin: got %h want 4000000000000000", p); else passed++;
    total++; if (ac !== 72'h0) $display("FAIL signed_clear_acc: got %h want 0", ac); else passed++;
  endtask

  task automatic test_accumulate;
    logic [63:0] p; logic [71:0] ac; logic ov; bit ok;
    run_one(0, 32'd2, 32'd3, 1, 1, 1, p, ac, ov, ok);
    total++; if (ac !== 72'd6) $display("FAIL acc_beat0: got %0d want 6", ac); else passed++;
    run_one(0, 32'd4, 32'd5, 1, 1, 0, p, ac, ov, ok);
    total++; if (ac !== 72'd26) $display("FAIL acc_beat1: got %0d want 26", ac); else passed++;
    run_one(0, 32'd6, 32'd7, 1, 1, 0, p, ac, ov, ok);
    total++; if (ac !== 72'd68) $display("FAIL acc_beat2: got %0d want 68", ac); else passed++;
    run_one(0, 32'd9, 32'd9, 1, 0, 0, p, ac, ov, ok);
    total++; if (ac !== 72'd68) $display("FAIL acc_noen: got %0d want 68", ac); else passed++;
    total++; if (p !== 64'd81) $display("FAIL acc_noen_prod: got %0d want 81", p); else passed++;
    total++; if (ov !== 1'b0) $display("FAIL acc_ovf_clear: got %b want 0", ov); else passed++;
  endtask

  task automatic test_back_to_back;
    logic [63:0] got[$];
    logic [63:0] held;
    logic [63:0] exp_p;
    @(posedge clk); #1;
    fork
      begin
        int i = 0;
        int cyc = 0;
        bit take;
        while (i < 6 && cyc < 60) begin
          in_valid = 1; a = i; b = i + 1; is_signed = 0; acc_en = 0; acc_clear = 0;
          @(negedge clk); take = in_ready;
          @(posedge clk); #1;
          if (take) i++;
          cyc++;
        end
        in_valid = 0;
      end
      begin
        for (int c = 0; c < 40; c++) begin
          @(negedge clk);
          if (out_valid && out_ready) got.push_back(prod);
        end
      end
      begin
        int w = 0;
        while (out_valid !== 1'b1 && w < 20) begin @(negedge clk); w++; end
        @(posedge clk); #1;
        out_ready = 0;
        held = prod;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          total++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready: cycle %0d got %b want 0", k, in_ready); else passed++;
          total++; if (prod !== held) $display("FAIL stall_prod_hold: cycle %0d got %h want %h", k, prod, held); else passed++;
        end
        @(posedge clk); #1;
        out_ready = 1;
      end
    join
    total++; if (got.size() != 6) $display("FAIL b2b_count: got %0d want 6", got.size()); else passed++;
    for (int i = 0; i < 6; i++) begin
      exp_p = 64'(i * (i + 1));
      total++;
      if (i >= got.size()) $display("FAIL b2b_prod%0d: got nothing want %0d", i, exp_p);
      else if (got[i] !== exp_p) $display("FAIL b2b_prod%0d: got %0d want %0d", i, got[i], exp_p);
      else passed++;
    end
  endtask

  task automatic test_overflow;
    logic [63:0] p; logic [71:0] ac; logic ov; bit ok;
    run_one(1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1, 1, 1, p, ac, ov, ok);
    total++; if (ac !== 72'h3FFF_FFFF_0000_0001) $display("FAIL ovf_beat0_acc: got %h want 3fffffff00000001", ac); else passed++;
    run_one(1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1, 1, 0, p, ac, ov, ok);
    total++; if (ac !== 72'h7FFF_FFFE_0000_0002) $display("FAIL ovf_beat1_acc: got %h want 7ffffffe00000002", ac); else passed++;
    total++; if (ov !== 1'b0) $display("FAIL ovf_beat1_flag: got %b want 0", ov); else passed++;
    run_one(1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1, 1, 0, p, ac, ov, ok);
    total++; if (ov !== 1'b1) $display("FAIL ovf_beat2_flag: got %b want 1", ov); else passed++;
    total++; if (ac !== 72'hBFFF_FFFD_0000_0003) $display("FAIL ovf_beat2_wrap: got %h want bffffffd00000003", ac); else passed++;
    run_one(1, 32'd1, 32'd1, 1, 1, 0, p, ac, ov, ok);
    total++; if (ov !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", ov); else passed++;
    total++; if (ac !== 72'hBFFF_FFFD_0000_0004) $display("FAIL ovf_sticky_acc: got %h want bffffffd00000004", ac); else passed++;
    run_one(1, 32'd1, 32'd1, 1, 1, 1, p, ac, ov, ok);
    total++; if (ov !== 1'b0) $display("FAIL ovf_clear_flag: got %b want 0", ov); else passed++;
    total++; if (ac !== 72'd1) $display("FAIL ovf_clear_acc: got %h want 1", ac); else passed++;
  endtask

  task automatic test_reset_mid;
    logic [63:0] p; logic [71:0] ac; logic ov; bit ok;
    int spurious = 0;
    @(posedge clk); #1;
    in_valid = 1; a = 3; b = 4; is_signed = 0; acc_en = 1; acc_clear = 0;
    repeat (3) @(posedge clk);
    #1 in_valid = 0;
    total++; if (out_valid !== 1'b1) $display("FAIL mid_pre_valid: got %b want 1", out_valid); else passed++;
    rst_n = 0;
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL mid_out_valid: got %b want 0", out_valid); else passed++;
    total++; if (acc !== 72'h0) $display("FAIL mid_acc: got %h want 0", acc); else passed++;
    total++; if (acc_ovf !== 1'b0) $display("FAIL mid_acc_ovf: got %b want 0", acc_ovf); else passed++;
    @(posedge clk); #1 rst_n = 1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) spurious++;
    end
    total++; if (spurious != 0) $display("FAIL mid_spurious: got %0d valid cycles want 0", spurious); else passed++;
    run_one(0, 32'd5, 32'd5, 0, 1, 0, p, ac, ov, ok);
    total++; if (!ok) $display("FAIL mid_latency: got early/late out_valid want 3 cycles"); else passed++;
    total++; if (ac !== 72'd25) $display("FAIL mid_acc_after: got %0d want 25", ac); else passed++;
  endtask

  initial begin
    test_reset;
    test_unsigned_max;
    test_signed;
    test_accumulate;
    test_back_to_back;
    test_overflow;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
